// File: rtl/lzc.sv
// Leading/trailing zero counter: MODE 0 counts trailing zeros, MODE 1 leading.
// empty_o flags an all-zero input; cnt_o is 0 in that case.
module lzc #(
    parameter int WIDTH = 8,
    parameter int MODE  = 0
) (
    input  logic [WIDTH-1:0]         in_i,
    output logic [$clog2(WIDTH)-1:0] cnt_o,
    output logic                     empty_o
);

    localparam int CW = $clog2(WIDTH);

    always_comb begin
        cnt_o   = '0;
        empty_o = ~|in_i;
        if (MODE == 0) begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (in_i[i]) cnt_o = CW'(i);
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (in_i[i]) cnt_o = CW'(WIDTH - 1 - i);
            end
        end
    end

endmodule

// File: rtl/bitmask_serializer.sv
// Serialises the set bits of a request mask into one index per handshake,
// lowest-first (MODE 0) or highest-first (MODE 1).
module bitmask_serializer #(
    parameter int WIDTH = 8,
    parameter int MODE  = 0,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] mask_i,
    input  logic             mask_valid_i,
    output logic             mask_ready_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             last_o,
    output logic             idx_valid_o,
    input  logic             idx_ready_i,
    output logic             busy_o
);

    if (WIDTH < 2) begin : g_width_check
        $error("bitmask_serializer: WIDTH must be >= 2");
    end

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] pending_q;
    logic [IDX_W-1:0] cnt;
    logic             empty;
    logic [IDX_W-1:0] idx_raw;
    logic [WIDTH-1:0] sel_onehot;
    logic [WIDTH-1:0] remain;
    logic             out_fire;
    logic             accept;

    lzc #(
        .WIDTH (WIDTH),
        .MODE  (MODE)
    ) u_lzc (
        .in_i    (pending_q),
        .cnt_o   (cnt),
        .empty_o (empty)
    );

    assign idx_raw    = (MODE == 0) ? cnt : IDX_W'(WIDTH - 1) - cnt;
    assign sel_onehot = WIDTH'(1) << idx_raw;
    assign remain     = pending_q & ~sel_onehot;

    assign busy_o      = (state_q == BUSY);
    assign idx_valid_o = busy_o;
    assign idx_o       = busy_o ? idx_raw : '0;
    assign last_o      = busy_o && (remain == '0);

    assign out_fire = idx_valid_o && idx_ready_i;
    // Taking a new mask alongside the final index keeps back-to-back masks bubble-free.
    assign mask_ready_o = !flush_i && (!busy_o || (out_fire && last_o));
    assign accept       = mask_valid_i && mask_ready_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            pending_q <= '0;
        end else if (flush_i) begin
            state_q   <= IDLE;
            pending_q <= '0;
        end else if (accept) begin
            pending_q <= mask_i;
            state_q   <= (mask_i != '0) ? BUSY : IDLE;
        end else if (out_fire) begin
            pending_q <= remain;
            if (last_o) state_q <= IDLE;
        end
    end

    a_busy_nonempty: assert property (
        @(posedge clk_i) disable iff (rst_i) (state_q == BUSY) |-> !empty
    );

endmodule

// File: tb/tb_bitmask_serializer.sv
// Directed bench for bitmask_serializer: MODE 0 and MODE 1 instances share
// stimulus; per-instance scoreboards check every emitted index.
module tb_bitmask_serializer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic [7:0] mask = '0;
    logic       mask_valid = 1'b0;
    logic       idx_ready = 1'b1;

    logic       r0, l0, v0, b0;
    logic [2:0] i0;
    logic       r1, l1, v1, b1;
    logic [2:0] i1;

    int total = 0;
    int bad   = 0;

    // Expected {last, idx}
    logic [3:0] q0[$];
    logic [3:0] q1[$];

    always #5 clk = ~clk;

    bitmask_serializer #(.WIDTH(8), .MODE(0)) u0 (
        .clk_i        (clk),
        .rst_i        (rst),
        .flush_i      (flush),
        .mask_i       (mask),
        .mask_valid_i (mask_valid),
        .mask_ready_o (r0),
        .idx_o        (i0),
        .last_o       (l0),
        .idx_valid_o  (v0),
        .idx_ready_i  (idx_ready),
        .busy_o       (b0)
    );

    bitmask_serializer #(.WIDTH(8), .MODE(1)) u1 (
        .clk_i        (clk),
        .rst_i        (rst),
        .flush_i      (flush),
        .mask_i       (mask),
        .mask_valid_i (mask_valid),
        .mask_ready_o (r1),
        .idx_o        (i1),
        .last_o       (l1),
        .idx_valid_o  (v1),
        .idx_ready_i  (idx_ready),
        .busy_o       (b1)
    );

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push0(input int idx, input bit last);
        q0.push_back({last, 3'(idx)});
    endtask

    task automatic push1(input int idx, input bit last);
        q1.push_back({last, 3'(idx)});
    endtask

    // Monitors: handshake on the coming edge is visible at the negedge
    always @(negedge clk) begin
        if (!rst && v0 && idx_ready) begin
            if (q0.size() == 0) begin
                check("m0_unexpected_idx", int'(i0), -1);
            end else begin
                logic [3:0] e;
                e = q0.pop_front();
                check("m0_idx", int'(i0), int'(e[2:0]));
                check("m0_last", int'(l0), int'(e[3]));
            end
        end
        if (!rst && v1 && idx_ready) begin
            if (q1.size() == 0) begin
                check("m1_unexpected_idx", int'(i1), -1);
            end else begin
                logic [3:0] e;
                e = q1.pop_front();
                check("m1_idx", int'(i1), int'(e[2:0]));
                check("m1_last", int'(l1), int'(e[3]));
            end
        end
    end

    task automatic check_idle(input string name);
        check({name, "_ready0"}, int'(r0), 1);
        check({name, "_valid0"}, int'(v0), 0);
        check({name, "_idx0"}, int'(i0), 0);
        check({name, "_last0"}, int'(l0), 0);
        check({name, "_busy0"}, int'(b0), 0);
        check({name, "_valid1"}, int'(v1), 0);
        check({name, "_busy1"}, int'(b1), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        tick();
        tick();
        @(negedge clk);
        check_idle("reset");
        tick();
        rst = 1'b0;

        // Basic serialisation, both modes
        mask = 8'hA6;
        mask_valid = 1'b1;
        push0(1, 0); push0(2, 0); push0(5, 0); push0(7, 1);
        push1(7, 0); push1(5, 0); push1(2, 0); push1(1, 1);
        tick();
        mask_valid = 1'b0;
        mask = 8'h00;
        @(negedge clk);
        check("a6_first_idx0", int'(i0), 1);
        check("a6_first_idx1", int'(i1), 7);
        check("a6_first_ready0", int'(r0), 0);
        tick(); tick(); tick();
        @(negedge clk);
        check("a6_last_idx0", int'(i0), 7);
        check("a6_last_ready0", int'(r0), 1);
        check("a6_last_last1", int'(l1), 1);
        tick();
        @(negedge clk);
        check_idle("a6_done");

        // Back-to-back masks
        tick();
        mask = 8'h81;
        mask_valid = 1'b1;
        push0(0, 0); push0(7, 1); push0(4, 1);
        push1(7, 0); push1(0, 1); push1(4, 1);
        tick();
        mask = 8'h10;
        @(negedge clk);
        check("b2b_ready_mid", int'(r0), 0);
        tick();
        @(negedge clk);
        check("b2b_idx7", int'(i0), 7);
        check("b2b_ready_last", int'(r0), 1);
        tick();
        mask_valid = 1'b0;
        @(negedge clk);
        check("b2b_no_bubble_busy", int'(b0), 1);
        check("b2b_no_bubble_idx", int'(i0), 4);
        tick();
        @(negedge clk);
        check_idle("b2b_done");

        // Stall while index 2 is presented
        tick();
        idx_ready = 1'b0;
        mask = 8'h0C;
        mask_valid = 1'b1;
        push0(2, 0); push0(3, 1);
        push1(3, 0); push1(2, 1);
        tick();
        mask_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_valid0", int'(v0), 1);
            check("stall_idx0", int'(i0), 2);
            check("stall_last0", int'(l0), 0);
            check("stall_idx1", int'(i1), 3);
            tick();
        end
        idx_ready = 1'b1;
        tick(); tick();
        @(negedge clk);
        check_idle("stall_done");

        // Zero mask is consumed silently
        tick();
        mask = 8'h00;
        mask_valid = 1'b1;
        tick();
        mask_valid = 1'b0;
        @(negedge clk);
        check("zero_valid0", int'(v0), 0);
        check("zero_ready0", int'(r0), 1);
        tick();
        mask = 8'h01;
        mask_valid = 1'b1;
        push0(0, 1);
        push1(0, 1);
        tick();
        mask_valid = 1'b0;
        tick();
        @(negedge clk);
        check_idle("zero_done");

        // Flush after two indices
        tick();
        mask = 8'hFF;
        mask_valid = 1'b1;
        push0(0, 0); push0(1, 0);
        push1(7, 0); push1(6, 0);
        tick();
        mask_valid = 1'b0;
        tick(); tick();
        idx_ready = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        check("flush_blocks_ready", int'(r0), 0);
        tick();
        flush = 1'b0;
        idx_ready = 1'b1;
        @(negedge clk);
        check_idle("flush_done");
        tick(); tick();

        // Asynchronous reset mid-serialisation
        mask = 8'hFF;
        mask_valid = 1'b1;
        push0(0, 0); push0(1, 0);
        push1(7, 0); push1(6, 0);
        tick();
        mask_valid = 1'b0;
        tick(); tick();
        #2;
        rst = 1'b1;
        #1;
        check_idle("async_rst");
        tick();
        rst = 1'b0;
        tick(); tick();
        @(negedge clk);
        check_idle("after_rst");

        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
